// File: rtl/move_input_ctrl.sv
// Button/tilt input conditioning for the vga top: synchronise, debounce, pick a source,
// cancel opposing directions and hold the result constant for a whole frame.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_BTN    | source is the debounced push buttons
// ST_TILT   | source is the tilt comparators
// ST_SWITCH | source forced to zero until the next vs_fall picks a side
module move_input_ctrl #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int DEAD_ZONE       = 4
) (
    input  logic        CLK100MHZ,
    input  logic        CPU_RESETN,
    input  logic        BTNU,
    input  logic        BTND,
    input  logic        BTNL,
    input  logic        BTNR,
    input  logic        tilt_en,
    input  logic [14:0] movementData,
    input  logic        VGA_VS,
    output logic        up,
    output logic        down,
    output logic        left,
    output logic        right,
    output logic        src_tilt
);

    localparam int              CNT_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_BTN    = 2'd0,
        ST_TILT   = 2'd1,
        ST_SWITCH = 2'd2
    } state_t;

    // Direction vectors are ordered {up, down, left, right} throughout.
    logic [3:0]       btn_raw;
    logic [3:0]       btn_s1;
    logic [3:0]       btn_s2;
    logic             te_s1;
    logic             te_s2;
    logic             vs_s1;
    logic             vs_s2;
    logic             vs_d;
    logic             vs_fall;

    logic [CNT_W-1:0] db_cnt [4];
    logic [3:0]       btn_stable;

    logic signed [4:0] tilt_x;
    logic signed [4:0] tilt_y;
    logic             tilt_up;
    logic             tilt_down;
    logic             tilt_left;
    logic             tilt_right;
    logic             unused_md;

    state_t           state;
    state_t           state_nxt;
    logic [3:0]       req;
    logic [3:0]       req_c;

    assign btn_raw   = {BTNU, BTND, BTNL, BTNR};
    assign unused_md = ^movementData[13:10];

    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            btn_s1  <= '0;
            btn_s2  <= '0;
            te_s1   <= 1'b0;
            te_s2   <= 1'b0;
            vs_s1   <= 1'b1;
            vs_s2   <= 1'b1;
            vs_d    <= 1'b1;
            vs_fall <= 1'b0;
        end else begin
            btn_s1  <= btn_raw;
            btn_s2  <= btn_s1;
            te_s1   <= tilt_en;
            te_s2   <= te_s1;
            vs_s1   <= VGA_VS;
            vs_s2   <= vs_s1;
            vs_d    <= vs_s2;
            vs_fall <= vs_d & ~vs_s2;
        end
    end

    // Any sample that matches the accepted level restarts the count, so bounce never accumulates.
    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            for (int i = 0; i < 4; i++) begin
                db_cnt[i] <= '0;
            end
            btn_stable <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (btn_s2[i] != btn_stable[i]) begin
                    if (db_cnt[i] == CNT_LAST) begin
                        btn_stable[i] <= btn_s2[i];
                        db_cnt[i]     <= '0;
                    end else begin
                        db_cnt[i] <= db_cnt[i] + CNT_W'(1);
                    end
                end else begin
                    db_cnt[i] <= '0;
                end
            end
        end
    end

    // movementData is already in this clock domain, so it is captured without a synchroniser.
    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            tilt_x <= '0;
            tilt_y <= '0;
        end else if (movementData[14]) begin
            tilt_x <= $signed(movementData[9:5]);
            tilt_y <= $signed(movementData[4:0]);
        end
    end

    assign tilt_left  = (int'(tilt_x) <= -DEAD_ZONE);
    assign tilt_right = (int'(tilt_x) >=  DEAD_ZONE);
    assign tilt_up    = (int'(tilt_y) <= -DEAD_ZONE);
    assign tilt_down  = (int'(tilt_y) >=  DEAD_ZONE);

    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            state <= ST_BTN;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        req       = '0;
        case (state)
            ST_BTN: begin
                req = btn_stable;
                if (te_s2) begin
                    state_nxt = ST_SWITCH;
                end
            end
            ST_TILT: begin
                req = {tilt_up, tilt_down, tilt_left, tilt_right};
                if (!te_s2) begin
                    state_nxt = ST_SWITCH;
                end
            end
            ST_SWITCH: begin
                if (vs_fall) begin
                    state_nxt = te_s2 ? ST_TILT : ST_BTN;
                end
            end
            default: begin
                state_nxt = ST_BTN;
            end
        endcase
    end

    assign req_c = {req[3] & ~req[2], req[2] & ~req[3], req[1] & ~req[0], req[0] & ~req[1]};

    // src_tilt is loaded with the outputs so it always names the source they came from.
    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            up       <= 1'b0;
            down     <= 1'b0;
            left     <= 1'b0;
            right    <= 1'b0;
            src_tilt <= 1'b0;
        end else if (vs_fall) begin
            {up, down, left, right} <= req_c;
            src_tilt                <= (state == ST_TILT);
        end
    end

endmodule

// File: tb/tb_move_input_ctrl.sv
// Frame-level bench for move_input_ctrl: 200-cycle frames with a 4-cycle VGA_VS low pulse,
// per-frame expectations queued with the stimulus and popped after each output update.
module tb_move_input_ctrl;

    logic        CLK100MHZ   = 1'b0;
    logic        CPU_RESETN  = 1'b0;
    logic        BTNU        = 1'b0;
    logic        BTND        = 1'b0;
    logic        BTNL        = 1'b0;
    logic        BTNR        = 1'b0;
    logic        tilt_en     = 1'b0;
    logic [14:0] movementData = '0;
    logic        VGA_VS      = 1'b1;
    logic        up;
    logic        down;
    logic        left;
    logic        right;
    logic        src_tilt;
    logic [4:0]  outs;

    int cyc   = 0;
    int total = 0;
    int bad   = 0;

    typedef struct {
        string      nm;
        logic [4:0] v;
    } exp_t;

    typedef struct {
        string       nm;
        logic [3:0]  btn;
        logic        te;
        logic [14:0] md;
        logic [4:0]  exp_v;
    } vec_t;

    exp_t exp_q[$];
    vec_t vecs[16];

    move_input_ctrl #(
        .DEBOUNCE_CYCLES(16),
        .DEAD_ZONE      (4)
    ) dut (
        .CLK100MHZ   (CLK100MHZ),
        .CPU_RESETN  (CPU_RESETN),
        .BTNU        (BTNU),
        .BTND        (BTND),
        .BTNL        (BTNL),
        .BTNR        (BTNR),
        .tilt_en     (tilt_en),
        .movementData(movementData),
        .VGA_VS      (VGA_VS),
        .up          (up),
        .down        (down),
        .left        (left),
        .right       (right),
        .src_tilt    (src_tilt)
    );

    assign outs = {up, down, left, right, src_tilt};

    always #5 CLK100MHZ = ~CLK100MHZ;

    always @(posedge CLK100MHZ) cyc <= cyc + 1;

    // VGA_VS is low for frame cycles 196..199; outputs then load on the edge where cycle%200 == 0.
    initial begin
        forever begin
            @(posedge CLK100MHZ);
            #1;
            VGA_VS = ((cyc % 200) < 196);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: run still active at time %0t, required to finish earlier", $time);
        $fatal(1);
    end

    function automatic logic [14:0] mk_md(input logic valid, input int x, input int y);
        logic [4:0] xb;
        logic [4:0] yb;
        xb = x[4:0];
        yb = y[4:0];
        return {valid, 4'b1010, xb, yb};
    endfunction

    task automatic check(input string nm, input logic [4:0] act, input logic [4:0] exp_v);
        total++;
        if (act !== exp_v) begin
            bad++;
            $display("FAIL %s: got {u,d,l,r,src}=%b, required %b (cycle %0d)", nm, act, exp_v, cyc);
        end
    endtask

    task automatic wait_mod(input int m);
        do begin
            @(posedge CLK100MHZ);
            #1;
        end while ((cyc % 200) != m);
    endtask

    task automatic set_btn(input logic [3:0] b);
        {BTNU, BTND, BTNL, BTNR} = b;
    endtask

    task automatic expect_frame(input string nm, input logic [4:0] v);
        exp_t e;
        e.nm = nm;
        e.v  = v;
        exp_q.push_back(e);
    endtask

    task automatic check_frame();
        exp_t e;
        wait_mod(0);
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard: output update at cycle %0d with no expectation queued", cyc);
        end else begin
            e = exp_q.pop_front();
            check(e.nm, outs, e.v);
        end
    endtask

    initial begin
        vecs[0]  = '{"idle",         4'b0000, 1'b0, 15'd0,              5'b00000};
        vecs[1]  = '{"btn_up",       4'b1000, 1'b0, 15'd0,              5'b10000};
        vecs[2]  = '{"cancel_ud",    4'b1101, 1'b0, 15'd0,              5'b00010};
        vecs[3]  = '{"cancel_lr",    4'b0011, 1'b0, 15'd0,              5'b00000};
        vecs[4]  = '{"down_left",    4'b0110, 1'b0, 15'd0,              5'b01100};
        vecs[5]  = '{"all_four",     4'b1111, 1'b0, 15'd0,              5'b00000};
        vecs[6]  = '{"to_switch",    4'b0000, 1'b1, mk_md(1, -16, 3),   5'b00000};
        vecs[7]  = '{"tilt_left",    4'b0000, 1'b1, mk_md(1, -16, 3),   5'b00101};
        vecs[8]  = '{"tilt_down",    4'b0000, 1'b1, mk_md(1, -16, 4),   5'b01101};
        vecs[9]  = '{"valid_low",    4'b0000, 1'b1, mk_md(0, 5, -5),    5'b01101};
        vecs[10] = '{"dead_zone",    4'b0000, 1'b1, mk_md(1, 3, -3),    5'b00001};
        vecs[11] = '{"edge_pos4",    4'b0000, 1'b1, mk_md(1, 4, -4),    5'b10011};
        vecs[12] = '{"edge_neg4",    4'b0000, 1'b1, mk_md(1, -4, 15),   5'b01101};
        vecs[13] = '{"btn_ignored",  4'b0001, 1'b1, mk_md(1, -3, -16),  5'b10001};
        vecs[14] = '{"back_switch",  4'b1000, 1'b0, mk_md(1, -3, -16),  5'b00000};
        vecs[15] = '{"btn_again",    4'b1000, 1'b0, mk_md(1, -3, -16),  5'b10000};

        repeat (3) @(posedge CLK100MHZ);
        #1;
        check("reset_outs", outs, 5'b00000);
        CPU_RESETN = 1'b1;
        expect_frame("reset_state", 5'b00000);
        check_frame();

        for (int i = 0; i < 16; i++) begin
            set_btn(vecs[i].btn);
            tilt_en      = vecs[i].te;
            movementData = vecs[i].md;
            expect_frame(vecs[i].nm, vecs[i].exp_v);
            check_frame();
        end

        // Debounce completes exactly at vs_fall (seen) versus one cycle later (next frame).
        set_btn(4'b0000);
        expect_frame("release1", 5'b00000);
        check_frame();
        wait_mod(181);
        BTNU = 1'b1;
        wait_mod(199);
        check("hold_before_vs", outs, 5'b00000);
        expect_frame("press_edge_in", 5'b10000);
        check_frame();
        set_btn(4'b0000);
        expect_frame("release2", 5'b00000);
        check_frame();
        wait_mod(182);
        BTNU = 1'b1;
        expect_frame("press_edge_late", 5'b00000);
        check_frame();
        expect_frame("press_edge_next", 5'b10000);
        check_frame();
        set_btn(4'b0000);
        expect_frame("release3", 5'b00000);
        check_frame();

        wait_mod(20);
        BTND = 1'b1;
        wait_mod(35);
        BTND = 1'b0;
        expect_frame("short_press", 5'b00000);
        check_frame();
        wait_mod(20);
        BTND = 1'b1;
        wait_mod(70);
        BTND = 1'b0;
        expect_frame("released_before_vs", 5'b00000);
        check_frame();

        // Bounce straddling a frame edge, every 5 cycles from cycle 150 to cycle 10 of the next frame.
        for (int i = 0; i < 10; i++) begin
            wait_mod(150 + 5 * i);
            BTNL = ~BTNL;
        end
        expect_frame("bounce_hidden", 5'b00000);
        check_frame();
        BTNL = ~BTNL;
        wait_mod(5);
        BTNL = ~BTNL;
        wait_mod(10);
        BTNL = ~BTNL;
        expect_frame("bounce_settled", 5'b00100);
        check_frame();

        // Synced tilt_en arrives on the same cycle as vs_fall.
        wait_mod(197);
        tilt_en      = 1'b1;
        movementData = mk_md(1, 5, 0);
        expect_frame("switch_on_vs_old", 5'b00100);
        check_frame();
        expect_frame("switch_on_vs_zero", 5'b00000);
        check_frame();
        expect_frame("switch_on_vs_tilt", 5'b00011);
        check_frame();

        wait_mod(10);
        tilt_en = 1'b0;
        wait_mod(50);
        tilt_en = 1'b1;
        expect_frame("switch_toggle_zero", 5'b00000);
        check_frame();
        expect_frame("switch_toggle_tilt", 5'b00011);
        check_frame();

        BTNL = 1'b0;
        wait_mod(179);
        tilt_en    = 1'b0;
        BTNR       = 1'b1;
        CPU_RESETN = 1'b0;
        #1;
        check("reset_async", outs, 5'b00000);
        wait_mod(182);
        CPU_RESETN = 1'b1;
        expect_frame("reset_release_late", 5'b00000);
        check_frame();
        expect_frame("reset_btn_right", 5'b00010);
        check_frame();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/move_input_ctrl.md
# move_input_ctrl

Input-conditioning stage directly upstream of the `vga` top. Turns the four push buttons and the tilt word `movementData` into the clean `up`/`down`/`left`/`right` levels that `vga` uses to compute square velocity. Inputs are synchronised and debounced, and opposite directions cancel. Outputs change only at the start of the vertical sync pulse, so each direction stays constant for a whole frame, including across `refresh_tick`.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 1000000: stable-level time in clocks before a button change is accepted (10 ms at 100 MHz).
- `DEAD_ZONE`, default 4: minimum tilt magnitude, in LSBs, that counts as a direction.

Ports:
- `CLK100MHZ`  in  1: system clock. Single clock domain.
- `CPU_RESETN`  in  1: reset, asynchronous, active-low.
- `BTNU`, `BTND`, `BTNL`, `BTNR`  in  1 each: raw buttons, active-high, asynchronous.
- `tilt_en`  in  1: slide switch, asynchronous. 1 selects tilt, 0 selects buttons.
- `movementData`  in  15: tilt word.
  - [14] = valid.
  - [9:5] = signed X; positive means right.
  - [4:0] = signed Y; positive means down.
  - [13:10] reserved and ignored.
- `VGA_VS`  in  1: vertical sync from `vga_controller_640_60`, active-low.
- `up`, `down`, `left`, `right`  out  1 each: frame-stable direction levels.
- `src_tilt`  out  1: 1 while the active source is tilt.

## Operation
- **Synchronisers.** Every asynchronous input gets a 2-FF chain: the four buttons, `tilt_en` and `VGA_VS`.
  - Reset value is 0 for all chains except `VGA_VS`, which resets to 1.
- **Debounce.** One counter and one `stable` bit per button.
  - If the synced value differs from `stable`: the counter increments.
  - When the counter reaches `DEBOUNCE_CYCLES-1`: `stable` takes the synced value and the counter clears.
  - If the synced value equals `stable`: the counter clears.
  - Any bounce therefore restarts the count.
- **Tilt capture.**
  - When `movementData[14]`=1, capture [9:0] into `tilt_x`/`tilt_y`. Otherwise hold the previous value.
  - `tilt_left` = `tilt_x` ≤ −DEAD_ZONE; `tilt_right` = `tilt_x` ≥ DEAD_ZONE (signed compare).
  - `tilt_up` = `tilt_y` ≤ −DEAD_ZONE; `tilt_down` = `tilt_y` ≥ DEAD_ZONE.
  - Example: −16 counts as left; ±3 counts as none.
- **Cancel rule.** Applied per axis after source selection.
  - If both `up` and `down` are requested, both go to 0.
  - If both `left` and `right` are requested, both go to 0.
  - Outputs never show two opposing directions at once.
- **Frame edge.** `vs_fall` is a one-cycle pulse when the synced `VGA_VS` goes from 1 to 0.
- **Source FSM.** States are BTN, TILT and SWITCH; reset state is BTN.
  - BTN: the source is the debounced buttons. If synced `tilt_en`=1, go to SWITCH.
  - TILT: the source is the tilt comparators. If synced `tilt_en`=0, go to SWITCH.
  - SWITCH: the source is forced to all-zero.
    - On `vs_fall`, go to BTN or TILT according to the current synced `tilt_en`.
    - If `tilt_en` toggles again while in SWITCH, stay in SWITCH and keep using the latest value.
  - `src_tilt` = (state == TILT), registered.
- **Output register.** On `vs_fall`, `up`/`down`/`left`/`right` load the cancelled request of the current source. Otherwise they hold.

## Timing
- Reset is asynchronous. On reset:
  - All outputs = 0.
  - All debounce counters and `stable` bits = 0.
  - `tilt_x` = `tilt_y` = 0.
  - FSM = BTN.
- Latency for a clean button press:
  - 2 cycles of synchroniser.
  - Plus `DEBOUNCE_CYCLES` cycles until `stable` flips.
  - Plus the wait until the next `vs_fall`. `vs_fall` occurs 3 cycles after `VGA_VS` falls: 2 sync stages plus the edge register.
  - The outputs update on the cycle after `vs_fall`.
- Outputs change at most once per frame and only on that cycle.
- If a press is shorter than `DEBOUNCE_CYCLES`, it is never seen.
- If a press is debounced but released before `vs_fall`, it is never seen.
- Tilt valid is captured on the same cycle it arrives, with no synchroniser. `movementData` is produced in the `CLK100MHZ` domain.
- If a source switch and `vs_fall` happen on the same cycle:
  - The FSM enters SWITCH.
  - The outputs load the old source's request.
  - The next `vs_fall` loads all-zero.
- If reset is asserted mid-frame, outputs clear immediately. After release, the first non-zero output appears at the first `vs_fall` that meets the debounce requirement.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=16 and a `VGA_VS` low pulse of 4 cycles every 200 cycles.

1. **Clean press.** Hold `BTNU` high from cycle 10.
   - `up`=1 from the cycle after the first `vs_fall` that follows cycle 28, and not before.
   - `down`/`left`/`right` stay 0.
2. **Bounce.** Toggle `BTNL` every 5 cycles for 60 cycles, then hold it high.
   - `left` stays 0 through the bounce.
   - `left` rises only at the first `vs_fall` that is ≥18 cycles after the final edge.
3. **Cancel.** Hold `BTNU` and `BTND` together, plus `BTNR`.
   - Output is `up`=0, `down`=0, `right`=1.
4. **Tilt.** Set `tilt_en`=1 and wait for the switch to complete, then send `movementData` with valid=1, X=−16 (5'b10000), Y=+3.
   - Across the switch: after the first `vs_fall`, outputs are all 0 and `src_tilt`=0.
   - After the second `vs_fall`: `left`=1, `up`=`down`=0, `src_tilt`=1.
   - Send Y=+4: `down`=1 at the next `vs_fall`.
   - Drop valid to 0 with the data changed: outputs are unchanged.
5. **Reset.** With `right`=1, pulse `CPU_RESETN` low for 3 cycles mid-frame.
   - All outputs go to 0 asynchronously.
   - The FSM returns to BTN.
   - With `BTNR` held, `right`=1 returns only at the first `vs_fall` after ≥18 clean cycles.
